// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding selects, shadow stage records.
package hazard_pkg;

  localparam int unsigned ZR_IDX_DEFAULT = 31;
  // Records store rd zero-extended to this width so the struct stays fixed-size.
  localparam int unsigned REG_W_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic                 wr;
    logic                 load;
    logic                 set_flags;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

endpackage

// File: rtl/src_match.sv
// Matches one ID source operand against the EX and MEM shadow records and picks the newest producer.
module src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned ZR_IDX = ZR_IDX_DEFAULT
) (
  input  logic             i_use,
  input  logic [REG_W-1:0] i_idx,
  input  stage_rec_t       i_exr,
  input  stage_rec_t       i_memr,
  output fwd_sel_t         o_sel,
  output logic             o_ex_hit
);

  logic [REG_W_MAX-1:0] w_idx_ext;
  logic                 w_live;
  logic                 w_mem_hit;
  logic                 w_unused;

  assign w_idx_ext = REG_W_MAX'(i_idx);
  // XZR reads as zero, so it never takes a forwarded value.
  assign w_live    = i_use && (i_idx != REG_W'(ZR_IDX));
  assign o_ex_hit  = w_live && i_exr.valid && i_exr.wr && (i_exr.rd == w_idx_ext);
  assign w_mem_hit = w_live && i_memr.valid && i_memr.wr && (i_memr.rd == w_idx_ext);
  assign w_unused  = ^{i_exr.load, i_exr.set_flags, i_memr.load, i_memr.set_flags};

  always_comb begin
    o_sel = FWD_RF;
    if (o_ex_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: load-use stall, operand and flag selects.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned ZR_IDX = ZR_IDX_DEFAULT,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_a,
  input  logic             id_use_b,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             id_set_flags,
  input  logic             id_use_flags,
  input  logic             ex_flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_flags
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  stage_rec_t r_exr, r_memr;
  stage_rec_t w_id_rec;
  fwd_sel_t   r_fwd_a, r_fwd_b;
  logic       r_fwd_flags;
  fwd_sel_t   w_sel_a, w_sel_b;
  logic       w_a_ex_hit, w_b_ex_hit;
  logic       w_use_a, w_use_b;
  logic       w_stall, w_flags, w_squash;

  // A non-valid ID slot must never request forwarding or a stall.
  assign w_use_a = id_valid & id_use_a;
  assign w_use_b = id_valid & id_use_b;

  src_match #(
    .REG_W  (REG_W),
    .ZR_IDX (ZR_IDX)
  ) u_src_a (
    .i_use    (w_use_a),
    .i_idx    (id_rn),
    .i_exr    (r_exr),
    .i_memr   (r_memr),
    .o_sel    (w_sel_a),
    .o_ex_hit (w_a_ex_hit)
  );

  src_match #(
    .REG_W  (REG_W),
    .ZR_IDX (ZR_IDX)
  ) u_src_b (
    .i_use    (w_use_b),
    .i_idx    (id_rm),
    .i_exr    (r_exr),
    .i_memr   (r_memr),
    .o_sel    (w_sel_b),
    .o_ex_hit (w_b_ex_hit)
  );

  // A flush squashes the ID instruction, so it cannot also stall.
  assign w_stall  = id_valid & r_exr.load & (w_a_ex_hit | w_b_ex_hit) & ~ex_flush;
  assign w_flags  = id_valid & id_use_flags & r_exr.set_flags;
  assign w_squash = w_stall | ex_flush;

  assign w_id_rec = '{valid:     id_valid,
                      rd:        REG_W_MAX'(id_rd),
                      wr:        id_wr,
                      load:      id_load,
                      set_flags: id_set_flags};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exr       <= BUBBLE;
      r_memr      <= BUBBLE;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_fwd_flags <= 1'b0;
    end else begin
      r_memr <= r_exr;
      if (w_squash) begin
        r_exr       <= BUBBLE;
        r_fwd_a     <= FWD_RF;
        r_fwd_b     <= FWD_RF;
        r_fwd_flags <= 1'b0;
      end else begin
        r_exr       <= w_id_rec;
        r_fwd_a     <= w_sel_a;
        r_fwd_b     <= w_sel_b;
        r_fwd_flags <= w_flags;
      end
    end
  end

  assign stall     = w_stall;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;
  assign fwd_flags = r_fwd_flags;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (ex_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Randomized scoreboard bench for hazard_fwd_ctrl with directed pipeline scenarios up front.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0, id_use_a = 1'b0, id_use_b = 1'b0;
  logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic       id_wr = 1'b0, id_load = 1'b0, id_set_flags = 1'b0, id_use_flags = 1'b0;
  logic       ex_flush = 1'b0;
  logic       stall, fwd_flags;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall_cnt = 0, m_flush_cnt = 0;
`endif

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .id_rd        (id_rd),
    .id_wr        (id_wr),
    .id_load      (id_load),
    .id_set_flags (id_set_flags),
    .id_use_flags (id_use_flags),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .fwd_flags    (fwd_flags)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  typedef struct {
    bit v;
    int rn, rm;
    bit ua, ub;
    int rd;
    bit wr, ld, sf, uf;
  } ins_t;

  typedef struct {
    bit stall;
    int fa, fb;
    bit ff;
  } exp_t;

  int   n_tests = 0, n_fail = 0;
  exp_t q[$];

  // Reference pipeline: the instructions currently in EX and MEM, plus selects latched for EX.
  ins_t ex_m, mem_m;
  int   p_fa = 0, p_fb = 0;
  bit   p_ff = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_stall", {31'd0, stall}, {31'd0, e.stall});
      chk("sb_fwd_a", {30'd0, fwd_a}, e.fa);
      chk("sb_fwd_b", {30'd0, fwd_b}, e.fb);
      chk("sb_fwd_flags", {31'd0, fwd_flags}, {31'd0, e.ff});
    end
  end

  function automatic ins_t mk(int rn, int rm, bit ua, bit ub, int rd, bit wr, bit ld, bit sf, bit uf);
    ins_t i;
    i = '{v: 1, rn: rn, rm: rm, ua: ua, ub: ub, rd: rd, wr: wr, ld: ld, sf: sf, uf: uf};
    return i;
  endfunction

  // Which stage holds the newest pending write to idx: 1 = EX, 2 = MEM, 0 = none/XZR.
  function automatic int producer(bit used, int idx);
    if (!used || idx == 31) return 0;
    if (ex_m.v && ex_m.wr && ex_m.rd == idx) return 1;
    if (mem_m.v && mem_m.wr && mem_m.rd == idx) return 2;
    return 0;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '{default: 0};
    return i;
  endfunction

  task automatic model_reset();
    ex_m  = nop();
    mem_m = nop();
    p_fa  = 0;
    p_fb  = 0;
    p_ff  = 0;
  endtask

  // Presents one ID instruction for one cycle; returns the DUT's stall and the model's stall.
  task automatic issue(input ins_t i, input bit flush, output bit dut_st, output bit exp_st);
    exp_t e;
    int   sa, sb;
    id_valid = i.v; id_rn = 5'(i.rn); id_rm = 5'(i.rm); id_use_a = i.ua; id_use_b = i.ub;
    id_rd = 5'(i.rd); id_wr = i.wr; id_load = i.ld; id_set_flags = i.sf; id_use_flags = i.uf;
    ex_flush = flush;
    sa = producer(i.v && i.ua, i.rn);
    sb = producer(i.v && i.ub, i.rm);
    e.stall = i.v && ex_m.ld && (sa == 1 || sb == 1) && !flush;
    e.fa = p_fa;
    e.fb = p_fb;
    e.ff = p_ff;
    q.push_back(e);
    exp_st = e.stall;
    mem_m = ex_m;
    if (e.stall || flush) begin
      ex_m = nop();
      p_fa = 0; p_fb = 0; p_ff = 0;
    end else begin
      p_fa = sa; p_fb = sb; p_ff = i.v && i.uf && ex_m.sf;
      ex_m = i;
    end
`ifdef HAZARD_PERF_EN
    if (e.stall) m_stall_cnt++;
    if (flush) m_flush_cnt++;
`endif
    #1 dut_st = stall;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 31 : r;
  endfunction

  initial begin
    bit   st, est;
    ins_t cur;
    bit   hold;

    model_reset();
    #12;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("rst_fwd_flags", {31'd0, fwd_flags}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD X1,X2,X3 ; SUB X4,X1,X5
    issue(mk(2, 3, 1, 1, 1, 1, 0, 0, 0), 0, st, est);
    issue(mk(1, 5, 1, 1, 4, 1, 0, 0, 0), 0, st, est);
    chk("addsub_stall", {31'd0, st}, 32'd0);
    chk("addsub_fwd_a", {30'd0, fwd_a}, 32'd1);
    // ADD X1 ; NOP ; ORR X6,X7,X1
    issue(mk(2, 3, 1, 1, 1, 1, 0, 0, 0), 0, st, est);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, st, est);
    issue(mk(7, 1, 1, 1, 6, 1, 0, 0, 0), 0, st, est);
    chk("orr_fwd_b", {30'd0, fwd_b}, 32'd2);
    // LDUR X9,[X2] ; ADD X3,X9,X9 (stalls once, then forwards from MEM/WB)
    issue(mk(2, 0, 1, 0, 9, 1, 1, 0, 0), 0, st, est);
    issue(mk(9, 9, 1, 1, 3, 1, 0, 0, 0), 0, st, est);
    chk("ldu_stall_first", {31'd0, st}, 32'd1);
    issue(mk(9, 9, 1, 1, 3, 1, 0, 0, 0), 0, st, est);
    chk("ldu_stall_second", {31'd0, st}, 32'd0);
    chk("ldu_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("ldu_fwd_b", {30'd0, fwd_b}, 32'd2);
    // ADD X31,X1,X2 ; ADD X5,X31,X31
    issue(mk(1, 2, 1, 1, 31, 1, 0, 0, 0), 0, st, est);
    issue(mk(31, 31, 1, 1, 5, 1, 0, 0, 0), 0, st, est);
    chk("xzr_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("xzr_fwd_b", {30'd0, fwd_b}, 32'd0);
    // SUBS ; B.cond
    issue(mk(1, 2, 1, 1, 4, 1, 0, 1, 0), 0, st, est);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 0, st, est);
    chk("flags_fwd", {31'd0, fwd_flags}, 32'd1);
    // Load-use coinciding with a flush
    issue(mk(2, 0, 1, 0, 9, 1, 1, 0, 0), 0, st, est);
    issue(mk(9, 9, 1, 1, 3, 1, 0, 0, 0), 1, st, est);
    chk("flush_no_stall", {31'd0, st}, 32'd0);
    chk("flush_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("flush_fwd_b", {30'd0, fwd_b}, 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", stall_cnt, m_stall_cnt);
    chk("perf_flush_cnt", flush_cnt, m_flush_cnt);
`endif

    // Randomized traffic; a stalled instruction is re-presented like a real IF/ID would.
    hold = 0;
    cur = nop();
    for (int n = 0; n < 1500; n++) begin
      bit fl;
      if (!hold) begin
        cur = mk(pick_reg(), pick_reg(), 1'($urandom), 1'($urandom), pick_reg(),
                 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
        cur.v = ($urandom_range(0, 7) != 0);
      end
      fl = ($urandom_range(0, 7) == 0);
      issue(cur, fl, st, est);
      hold = est;
    end
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt_rand", stall_cnt, m_stall_cnt);
    chk("perf_flush_cnt_rand", flush_cnt, m_flush_cnt);
`endif

    // Asynchronous reset while EX holds a load with a dependent instruction in ID.
    issue(mk(2, 0, 1, 0, 9, 1, 1, 0, 0), 0, st, est);
    issue(mk(4, 5, 1, 1, 6, 1, 0, 0, 0), 0, st, est);
    repeat (2) @(negedge clk);
    id_valid = 1; id_rn = 5'd4; id_rm = 5'd5; id_use_a = 1; id_use_b = 1; id_rd = 5'd9;
    id_wr = 1; id_load = 1; id_set_flags = 0; id_use_flags = 0; ex_flush = 0;
    @(posedge clk);
    #1;
    id_rn = 5'd9; id_rm = 5'd9; id_rd = 5'd3; id_load = 0;
    #1;
    chk("prereset_stall", {31'd0, stall}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("async_rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("async_rst_fwd_flags", {31'd0, fwd_flags}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
`ifdef HAZARD_PERF_EN
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    issue(mk(9, 9, 1, 1, 3, 1, 0, 0, 0), 0, st, est);
    chk("post_rst_stall", {31'd0, st}, 32'd0);
    issue(nop(), 0, st, est);
    chk("post_rst_fwd_a", {30'd0, fwd_a}, 32'd0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) chk("sb_drain", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage ARM64 pipeline.
- Tracks the destination register of each in-flight instruction in EX and MEM shadow records.
- Drives the select lines of the ALU operand-forwarding mux2 trees and the flag-forwarding mux.
- Issues load-use stalls and injects bubbles on stall or branch flush.

Parameters:
- REG_W, 5, register index width.
- ZR_IDX, 31, index of XZR; never a forwarding source.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rn  in  REG_W  source A index.
- id_rm  in  REG_W  source B index (Rm, or Rt for STUR/CBZ).
- id_use_a, id_use_b  in  1 each  source actually read.
- id_rd  in  REG_W  destination index.
- id_wr  in  1  writes the register file.
- id_load  in  1  LDUR.
- id_set_flags  in  1  ADDS/SUBS.
- id_use_flags  in  1  B.cond.
- ex_flush  in  1  taken branch resolved in EX.
- stall  out  1  hold PC and IF/ID; combinational.
- fwd_a, fwd_b  out  2 each  registered EX operand selects: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_flags  out  1  registered; B.cond in EX takes flags from the EX/MEM flag register.

Behaviour:
- Shadow records EXR and MEMR each hold {valid, rd, wr, load, set_flags}. Reset: all fields 0.
- All outputs reset to 0.
- An ID source matches record R when all of these hold:
  - the source's use bit is 1;
  - R.valid and R.wr are 1;
  - R.rd equals the source index;
  - the source index is not ZR_IDX.
- Load-use stall: stall = id_valid & EXR.load & (A matches EXR or B matches EXR) & ~ex_flush.
- Priority per source:
  - match EXR gives 01;
  - otherwise match MEMR gives 10;
  - otherwise 00.
  - EXR beats MEMR because it is the newer value.
- Flag forwarding: id_use_flags and EXR.set_flags gives 1; otherwise 0. Flags written by MEMR are already architectural.
- Each rising clk:
  - MEMR <= EXR, always.
  - If stall or ex_flush: EXR <= bubble (valid=0), and fwd_a, fwd_b, fwd_flags <= 0.
  - Else: EXR <= {id_valid, id_rd, id_wr, id_load, id_set_flags}, and the selects take their computed values.
- Latency: selects are computed in ID and registered, so they are valid while the instruction is in EX. stall is zero-latency.
- ex_flush wins over stall; a squashed ID instruction never stalls.
- Back-to-back loads: a second stall cannot occur, because the bubble clears EXR.load.
- Reset mid-operation: records and outputs clear immediately; the first instruction after reset sees no hazards.
- id_valid=0: all selects are 00 and there is no stall, regardless of the other inputs.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - adds output stall_cnt [CNT_W] and output flush_cnt [CNT_W];
  - each increments by 1 per cycle with stall or ex_flush high respectively;
  - both saturate at all-ones and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg:
  - enum fwd_sel_t {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10};
  - struct stage_rec_t;
  - BUBBLE constant;
  - ZR_IDX default.
- Sub-module src_match, instantiated twice (A and B): combinational match and priority encode, returning fwd_sel_t plus the EX-match bit for the stall term.

Test Plan:
- ADD X1,X2,X3 then SUB X4,X1,X5 → fwd_a=01 during the SUB's EX cycle; stall=0.
- ADD X1 then NOP then ORR X6,X7,X1 → fwd_b=10 in the ORR's EX cycle.
- LDUR X9,[X2] then ADD X3,X9,X9 → stall=1 for exactly one cycle. The bubble enters EX, then the ADD is re-presented and gets fwd_a=fwd_b=10.
- ADD X31,X1,X2 then ADD X5,X31,X31 → fwd_a=fwd_b=00 (XZR is never forwarded). Separately, SUBS then B.cond → fwd_flags=1.
- Load-use hazard with ex_flush=1 in the same cycle → stall=0. EXR becomes a bubble and the next cycle's selects are 00. With HAZARD_PERF_EN defined, flush_cnt increments by 1 and stall_cnt does not.
- Assert reset_n=0 mid-stream with EXR holding a load → stall and all selects drop to 0 asynchronously. After release, the counters read 0.
